m_alu_exec: RTL and testbench



---
 rtl/m_alu_pkg.sv | 19 +
 rtl/m_alu_exec_if.sv | 27 ++
 rtl/m_seq_mul.sv | 70 +++++++
 rtl/m_alu_exec.sv | 124 ++++++++++++
 tb/tb_m_alu_exec.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/m_alu_pkg.sv
// rtl/m_alu_pkg.sv - shared ALU op codes and handshake FSM state encoding
package m_alu_pkg;

    localparam int ALU_CTRL_W = 3;

    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_CTRL_W-1:0] ALU_MUL = 3'b011;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'b111;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_MUL  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/m_alu_exec_if.sv
// rtl/m_alu_exec_if.sv - execute-stage ALU handshake and operand/result bundle
interface m_alu_exec_if
    import m_alu_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  flush;
    logic [ALU_CTRL_W-1:0] alucontrol;
    logic [WIDTH-1:0]      srca;
    logic [WIDTH-1:0]      srcb;
    logic [WIDTH-1:0]      result;
    logic                  zero;
    logic                  out_valid;
    logic                  busy;

    modport master (
        output in_valid, flush, alucontrol, srca, srcb,
        input  in_ready, result, zero, out_valid, busy
    );

    modport slave (
        input  in_valid, flush, alucontrol, srca, srcb,
        output in_ready, result, zero, out_valid, busy
    );
endinterface

// File: rtl/m_seq_mul.sv
// rtl/m_seq_mul.sv - iterative shift-add multiplier, one partial product per cycle
module m_seq_mul #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             kill,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             run_q, run_d;
    logic [WIDTH-1:0] acc_next;
    logic             last;

    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign last     = run_q && (cnt_q == CW'(WIDTH - 1));
    // The final partial product is folded in combinationally so the caller can register it on the last step.
    assign done     = last;
    assign product  = acc_next;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        if (kill) begin
            run_d = 1'b0;
        end else if (start) begin
            mcand_d  = multiplicand;
            mplier_d = multiplier;
            acc_d    = '0;
            cnt_d    = '0;
            run_d    = 1'b1;
        end else if (run_q) begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (last) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end
endmodule

// File: rtl/m_alu_exec.sv
// rtl/m_alu_exec.sv - EX-stage ALU with registered result/zero and MUL stall handshake
// M_ALU_FAST_MUL_EN: single-cycle combinational MUL, no busy stall.
module m_alu_exec
    import m_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    m_alu_exec_if.slave   bus
);
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             out_valid_q, out_valid_d;
    logic             accept;

    always_comb begin
        alu_res = '0;
        case (bus.alucontrol)
            ALU_AND: alu_res = bus.srca & bus.srcb;
            ALU_OR:  alu_res = bus.srca | bus.srcb;
            ALU_ADD: alu_res = bus.srca + bus.srcb;
            ALU_SUB: alu_res = bus.srca - bus.srcb;
            ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.srca) < $signed(bus.srcb))};
`ifdef M_ALU_FAST_MUL_EN
            ALU_MUL: alu_res = bus.srca * bus.srcb;
`endif
            default: alu_res = '0;
        endcase
    end

`ifdef M_ALU_FAST_MUL_EN
    assign bus.busy     = 1'b0;
    assign bus.in_ready = 1'b1;
    assign accept       = bus.in_valid & ~bus.flush;

    always_comb begin
        result_d    = result_q;
        zero_d      = zero_q;
        out_valid_d = 1'b0;
        if (accept) begin
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            out_valid_d = 1'b1;
        end
    end
`else
    state_t           state_q, state_d;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    assign bus.busy     = (state_q == ST_MUL);
    assign bus.in_ready = ~bus.busy;
    assign accept       = bus.in_valid & bus.in_ready & ~bus.flush;

    m_seq_mul #(.WIDTH(WIDTH)) u_seq_mul (
        .clk          (clk),
        .reset        (reset),
        .start        (mul_start),
        .kill         (bus.flush),
        .multiplicand (bus.srca),
        .multiplier   (bus.srcb),
        .done         (mul_done),
        .product      (mul_product)
    );

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        zero_d      = zero_q;
        out_valid_d = 1'b0;
        mul_start   = 1'b0;
        if (bus.flush) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_MUL) begin
            if (mul_done) begin
                result_d    = mul_product;
                zero_d      = (mul_product == '0);
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
        end else begin
            // DONE accepts like IDLE, so a new op can issue in the completion cycle.
            state_d = ST_IDLE;
            if (accept) begin
                if (bus.alucontrol == ALU_MUL) begin
                    mul_start = 1'b1;
                    state_d   = ST_MUL;
                end else begin
                    result_d    = alu_res;
                    zero_d      = (alu_res == '0);
                    out_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q    <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_m_alu_exec.sv
// tb/tb_m_alu_exec.sv - scoreboard bench for the EX-stage ALU
module tb_m_alu_exec;
    import m_alu_pkg::*;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [W-1:0] last_res = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    m_alu_exec_if #(.WIDTH(W)) bus();

    m_alu_exec #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_pulse got result=%h expected no pulse", bus.result);
            end else begin
                mon_e = exp_q.pop_front();
                total++;
                if (bus.result !== mon_e.res) begin
                    bad++;
                    $display("FAIL sb_result got=%h expected=%h", bus.result, mon_e.res);
                end
                total++;
                if (bus.zero !== mon_e.z) begin
                    bad++;
                    $display("FAIL sb_zero got=%b expected=%b", bus.zero, mon_e.z);
                end
                last_res = mon_e.res;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.in_valid   = 1'b0;
        bus.alucontrol = '0;
        bus.srca       = '0;
        bus.srcb       = '0;
    endtask

    task automatic drive(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.in_valid   = 1'b1;
        bus.alucontrol = c;
        bus.srca       = a;
        bus.srcb       = b;
    endtask

    task automatic push_exp(input logic [W-1:0] r, input logic z);
        exp_t e;
        e.res = r;
        e.z   = z;
        exp_q.push_back(e);
    endtask

    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] r,
                           input bit hold_add, output int lat, output int busy_cnt, output int ready_bad);
        int start;
        start     = cyc;
        lat       = -1;
        busy_cnt  = 0;
        ready_bad = 0;
        drive(ALU_MUL, a, b);
        push_exp(r, r == '0);
        for (int i = 0; i < 60; i++) begin
            step();
            if (hold_add) drive(ALU_ADD, 32'd9, 32'd9);
            else idle_in();
            if (bus.busy === 1'b1) begin
                busy_cnt++;
                if (bus.in_ready !== 1'b0) ready_bad++;
            end
            if (bus.out_valid === 1'b1) begin
                lat = cyc - start;
                idle_in();
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.flush = 1'b0;
        idle_in();
        step();
        step();
        total++; if (bus.result !== '0)    begin bad++; $display("FAIL rst_result got=%h expected=0", bus.result); end
        total++; if (bus.zero !== 1'b0)    begin bad++; $display("FAIL rst_zero got=%b expected=0", bus.zero); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b expected=0", bus.out_valid); end
        total++; if (bus.busy !== 1'b0)    begin bad++; $display("FAIL rst_busy got=%b expected=0", bus.busy); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b expected=1", bus.in_ready); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_alu_seq();
        drive(ALU_ADD, 32'd5, 32'd7);          push_exp(32'd12, 1'b0);
        step();
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL seq_pulse_add got=%b expected=1", bus.out_valid); end
        drive(ALU_SUB, 32'd7, 32'd7);          push_exp(32'd0, 1'b1);
        step();
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL seq_pulse_sub got=%b expected=1", bus.out_valid); end
        drive(ALU_SLT, 32'hFFFF_FFFF, 32'd1);  push_exp(32'd1, 1'b0);
        step();
        idle_in();
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL seq_pulse_slt got=%b expected=1", bus.out_valid); end
        step();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL seq_pulse_end got=%b expected=0", bus.out_valid); end
        total++; if (bus.result !== 32'd1)   begin bad++; $display("FAIL seq_hold got=%h expected=1", bus.result); end
    endtask

    task automatic test_reset_mid_mul();
        drive(ALU_MUL, 32'd7, 32'd9);
        step();
        idle_in();
        repeat (9) step();
        reset = 1'b1;
        #1;
        total++; if (bus.result !== '0)      begin bad++; $display("FAIL mid_rst_result got=%h expected=0", bus.result); end
        total++; if (bus.zero !== 1'b0)      begin bad++; $display("FAIL mid_rst_zero got=%b expected=0", bus.zero); end
        total++; if (bus.busy !== 1'b0)      begin bad++; $display("FAIL mid_rst_busy got=%b expected=0", bus.busy); end
        total++; if (bus.in_ready !== 1'b1)  begin bad++; $display("FAIL mid_rst_in_ready got=%b expected=1", bus.in_ready); end
        step();
        reset = 1'b0;
        step();
        drive(ALU_ADD, 32'd1, 32'd1);  push_exp(32'd2, 1'b0);
        step();
        idle_in();
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL post_rst_pulse got=%b expected=1", bus.out_valid); end
        total++; if (bus.result !== 32'd2)   begin bad++; $display("FAIL post_rst_add got=%h expected=2", bus.result); end
        step();
    endtask

    task automatic test_mul_latency();
        int lat, bc, rb;
        run_mul(32'h0001_0003, 32'h0000_0005, 32'h0005_000F, 1'b1, lat, bc, rb);
        total++; if (lat !== 33)  begin bad++; $display("FAIL mul_latency got=%0d expected=33", lat); end
        total++; if (bc !== 32)   begin bad++; $display("FAIL mul_busy_cycles got=%0d expected=32", bc); end
        total++; if (rb !== 0)    begin bad++; $display("FAIL mul_ready_while_busy got=%0d expected=0", rb); end
        step();
        step();
    endtask

    task automatic test_back_to_back();
        int lat, bc, rb;
        run_mul(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, lat, bc, rb);
        total++; if (lat !== 33) begin bad++; $display("FAIL wrap_latency got=%0d expected=33", lat); end
        run_mul(32'd3, 32'd4, 32'd12, 1'b0, lat, bc, rb);
        total++; if (lat !== 33) begin bad++; $display("FAIL b2b_latency got=%0d expected=33", lat); end
        step();
    endtask

    task automatic test_flush();
        drive(ALU_MUL, 32'd5, 32'd6);
        step();
        idle_in();
        repeat (9) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        total++; if (bus.busy !== 1'b0)      begin bad++; $display("FAIL flush_busy got=%b expected=0", bus.busy); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_pulse got=%b expected=0", bus.out_valid); end
        total++; if (bus.result !== 32'd12)  begin bad++; $display("FAIL flush_result got=%h expected=c", bus.result); end
        repeat (40) step();
        bus.flush = 1'b1;
        drive(ALU_ADD, 32'd2, 32'd3);
        step();
        bus.flush = 1'b0;
        idle_in();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_add_pulse got=%b expected=0", bus.out_valid); end
        total++; if (bus.result !== 32'd12)  begin bad++; $display("FAIL flush_add_result got=%h expected=c", bus.result); end
        step();
    endtask

    task automatic test_illegal();
        drive(3'b100, 32'd3, 32'd4);  push_exp(32'd0, 1'b1);
        step();
        idle_in();
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL illegal_pulse got=%b expected=1", bus.out_valid); end
        total++; if (bus.zero !== 1'b1)      begin bad++; $display("FAIL illegal_zero got=%b expected=1", bus.zero); end
        drive(ALU_OR, 32'hF0, 32'h0F);  push_exp(32'hFF, 1'b0);
        step();
        drive(3'b101, 32'd3, 32'd4);    push_exp(32'd0, 1'b1);
        step();
        drive(ALU_AND, 32'hF0, 32'h3C); push_exp(32'h30, 1'b0);
        step();
        idle_in();
        repeat (3) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu_seq();
        test_reset_mid_mul();
        test_mul_latency();
        test_back_to_back();
        test_flush();
        test_illegal();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain got=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
